neuron_mac_stream: RTL

Parametrised, pipelined multiply-accumulate unit for the neuron datapath. It consumes a stream of signed (x, weight) pairs over a valid/ready handshake and accumulates each vector onto a preloaded bias. It applies saturating arithmetic and optional ReLU, then presents one result per vector on a valid/ready output. It replaces the free-running single-width accumulator in the neuron core and adds vector framing, back-pressure, overflow handling and length checking.

---
 rtl/neuron_pkg.sv | 35 +++
 rtl/neuron_mac_stream_sat_add.sv | 39 +++
 rtl/neuron_mac_stream.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared widths, the stage-1 pipeline entry and the saturation helper for the
// neuron multiply-accumulate datapath.
package neuron_pkg;

  localparam int unsigned NEURON_DATA_W = 8;
  localparam int unsigned NEURON_ACC_W  = 20;
  localparam int unsigned NEURON_PROD_W = 2 * NEURON_DATA_W;
  localparam int unsigned NEURON_SUM_W  = NEURON_ACC_W + 1;

  // One multiplied element waiting for the accumulator.
  typedef struct packed {
    logic signed [NEURON_PROD_W-1:0] product;
    logic                            first;
    logic                            last;
  } s1_entry_t;

  // Clamp a one-bit-wider sum into the accumulator range; ovf flags a clamp.
  function automatic logic signed [NEURON_ACC_W-1:0] sat_clamp(
    input  logic signed [NEURON_SUM_W-1:0] sum,
    output logic                           ovf
  );
    logic signed [NEURON_ACC_W-1:0] res;
    // The extra top bit disagrees with the accumulator sign bit only on overflow.
    ovf = sum[NEURON_SUM_W-1] ^ sum[NEURON_SUM_W-2];
    if (!ovf) begin
      res = sum[NEURON_ACC_W-1:0];
    end else if (sum[NEURON_SUM_W-1]) begin
      res = {1'b1, {(NEURON_ACC_W-1){1'b0}}};
    end else begin
      res = {1'b0, {(NEURON_ACC_W-1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/neuron_mac_stream_sat_add.sv
// Combinational saturating adder: o_sum_c = sat(i_a + sext(i_b)).
// Ports:
//   i_a      ACC_W signed accumulator operand
//   i_b      B_W   signed addend, sign-extended before the add
//   o_sum_c  ACC_W signed clamped sum
//   o_sat_c  1     the sum was clamped
module neuron_sat_add
  import neuron_pkg::*;
#(
  parameter int unsigned ACC_W = NEURON_ACC_W,
  parameter int unsigned B_W   = NEURON_PROD_W
) (
  input  logic signed [ACC_W-1:0] i_a,
  input  logic signed [B_W-1:0]   i_b,
  output logic signed [ACC_W-1:0] o_sum_c,
  output logic                    o_sat_c
);

  localparam int unsigned SUM_W = ACC_W + 1;

  // The clamp helper is sized by the package accumulator width.
  if (SUM_W != NEURON_SUM_W) begin : g_bad_acc_w
    $error("neuron_sat_add: ACC_W must equal neuron_pkg::NEURON_ACC_W");
  end
  if (B_W >= SUM_W) begin : g_bad_b_w
    $error("neuron_sat_add: B_W must be narrower than ACC_W+1");
  end

  logic signed [SUM_W-1:0] w_sum;

  assign w_sum = SUM_W'(i_a) + SUM_W'(i_b);

  // Clamp the wide sum back to the accumulator range.
  always_comb begin
    o_sat_c = 1'b0;
    o_sum_c = sat_clamp(w_sum, o_sat_c);
  end

endmodule

// File: rtl/neuron_mac_stream.sv
// Pipelined signed multiply-accumulate over framed (x, weight) vectors.
// Stage 1 registers the product; stage 2 accumulates onto a bias sampled with
// the first element, saturates, applies optional ReLU and loads the output
// register on the last element (or at MAX_LEN, flagging a length error).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_clear           synchronous abort of pipeline and partial vector
//   i_bias, i_relu_en per-vector controls, sampled with the first element
//   i_in_valid/o_in_ready, i_in_x, i_in_w, i_in_last   element stream
//   o_out_valid/i_out_ready, o_out_data, o_out_count,
//   o_out_sat, o_out_len_err                           result stream
module neuron_mac_stream
  import neuron_pkg::*;
#(
  parameter  int unsigned DATA_W  = NEURON_DATA_W,
  parameter  int unsigned ACC_W   = NEURON_ACC_W,
  parameter  int unsigned MAX_LEN = 16,
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic signed [ACC_W-1:0]  i_bias,
  input  logic                     i_relu_en,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic signed [DATA_W-1:0] i_in_x,
  input  logic signed [DATA_W-1:0] i_in_w,
  input  logic                     i_in_last,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic signed [ACC_W-1:0]  o_out_data,
  output logic [CNT_W-1:0]         o_out_count,
  output logic                     o_out_sat,
  output logic                     o_out_len_err
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  if (ACC_W < 2 * DATA_W + 1) begin : g_bad_acc_range
    $error("neuron_mac_stream: ACC_W must be at least 2*DATA_W+1");
  end
  if (DATA_W != NEURON_DATA_W || ACC_W != NEURON_ACC_W) begin : g_bad_pkg_w
    $error("neuron_mac_stream: DATA_W/ACC_W must match neuron_pkg widths");
  end
  if (MAX_LEN < 1) begin : g_bad_max_len
    $error("neuron_mac_stream: MAX_LEN must be at least 1");
  end

  // Stage 1 registers.
  logic                    r_s1_valid;
  s1_entry_t               r_s1;
  logic signed [ACC_W-1:0] r_s1_bias;
  logic                    r_s1_relu;
  logic [CNT_W-1:0]        r_in_cnt;

  // Stage 2 (accumulator) registers.
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_sat;
  logic                    r_relu;

  // Output registers.
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_out_data;
  logic [CNT_W-1:0]        r_out_count;
  logic                    r_out_sat;
  logic                    r_out_len_err;

  logic                     w_accept;
  logic [CNT_W-1:0]         w_in_cnt_next;
  logic                     w_in_end;
  logic signed [PROD_W-1:0] w_product;
  s1_entry_t                w_s1_next;
  logic signed [ACC_W-1:0]  w_base;
  logic signed [ACC_W-1:0]  w_add_sum;
  logic                     w_add_sat;
  logic [CNT_W-1:0]         w_cnt_next;
  logic                     w_trunc;
  logic                     w_vec_end;
  logic                     w_relu_vec;
  logic                     w_sat_vec;
  logic                     w_s1_consume;
  logic signed [ACC_W-1:0]  w_result;

  // Input side: the element counter mirrors stage 2 so that the first flag of
  // the element following a MAX_LEN truncation is already correct in stage 1.
  assign w_accept      = i_in_valid && o_in_ready && !i_clear;
  assign w_in_cnt_next = r_in_cnt + CNT_W'(1);
  assign w_in_end      = i_in_last || (w_in_cnt_next == CNT_W'(MAX_LEN));
  assign w_product     = PROD_W'(i_in_x) * PROD_W'(i_in_w);

  always_comb begin
    w_s1_next         = '0;
    w_s1_next.product = w_product;
    w_s1_next.first   = (r_in_cnt == '0);
    w_s1_next.last    = i_in_last;
  end

  // Stage 2: accumulate onto the bias for a first element, else onto acc.
  assign w_base = r_s1.first ? r_s1_bias : r_acc;

  neuron_sat_add #(
    .ACC_W (ACC_W),
    .B_W   (PROD_W)
  ) u_sat_add (
    .i_a     (w_base),
    .i_b     (r_s1.product),
    .o_sum_c (w_add_sum),
    .o_sat_c (w_add_sat)
  );

  assign w_cnt_next   = r_s1.first ? CNT_W'(1) : (r_cnt + CNT_W'(1));
  assign w_trunc      = !r_s1.last && (w_cnt_next == CNT_W'(MAX_LEN));
  assign w_vec_end    = r_s1.last || w_trunc;
  assign w_relu_vec   = r_s1.first ? r_s1_relu : r_relu;
  assign w_sat_vec    = w_add_sat || (!r_s1.first && r_sat);
  assign w_result     = (w_relu_vec && w_add_sum[ACC_W-1]) ? '0 : w_add_sum;

  // A vector-ending entry waits while a previous result is still unaccepted.
  assign w_s1_consume = r_s1_valid && (!w_vec_end || !r_out_valid || i_out_ready);
  assign o_in_ready   = !r_s1_valid || w_s1_consume;

  // Stage 1 register and input element counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
      r_s1_bias  <= '0;
      r_s1_relu  <= 1'b0;
      r_in_cnt   <= '0;
    end else if (i_clear) begin
      r_s1_valid <= 1'b0;
      r_in_cnt   <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1       <= w_s1_next;
      r_s1_bias  <= i_bias;
      r_s1_relu  <= i_relu_en;
      r_in_cnt   <= w_in_end ? '0 : w_in_cnt_next;
    end else if (w_s1_consume) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2 accumulator, element count and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
      r_relu <= 1'b0;
    end else if (i_clear) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
      r_relu <= 1'b0;
    end else if (w_s1_consume) begin
      r_acc <= w_add_sum;
      if (w_vec_end) begin
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_next;
        r_sat  <= w_sat_vec;
        r_relu <= w_relu_vec;
      end
    end
  end

  // Output register: a new result may load in the same cycle as an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_count   <= '0;
      r_out_sat     <= 1'b0;
      r_out_len_err <= 1'b0;
    end else if (i_clear) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_count   <= '0;
      r_out_sat     <= 1'b0;
      r_out_len_err <= 1'b0;
    end else if (w_s1_consume && w_vec_end) begin
      r_out_valid   <= 1'b1;
      r_out_data    <= w_result;
      r_out_count   <= w_cnt_next;
      r_out_sat     <= w_sat_vec;
      r_out_len_err <= w_trunc;
    end else if (i_out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_out_data    = r_out_data;
  assign o_out_count   = r_out_count;
  assign o_out_sat     = r_out_sat;
  assign o_out_len_err = r_out_len_err;

endmodule
